// File: rtl/mmio_bridge_if.sv
// CPU data-port and device-channel signal bundle for mmio_bridge.
// The bridge takes the slave view; the CPU/device environment takes the master view.
interface mmio_bridge_if #(
  parameter int NUM_DEV = 2
);
  logic                   cpu_req;
  logic [31:0]            cpu_addr;
  logic [31:0]            cpu_wdata;
  logic [3:0]             cpu_we;
  logic [31:0]            cpu_rdata;
  logic                   cpu_stall;
  logic                   cpu_err;
  logic [NUM_DEV-1:0]     dev_req;
  logic [31:0]            dev_addr;
  logic [31:0]            dev_wdata;
  logic [3:0]             dev_we;
  logic [NUM_DEV-1:0]     dev_ready;
  logic [NUM_DEV*32-1:0]  dev_rdata;
  logic [NUM_DEV-1:0]     dev_irq;
  logic [NUM_DEV-1:0]     irq_out;

  // CPU side: cpu_req is held with addr/data/we stable while cpu_stall is high;
  // the access completes in the cycle where cpu_req=1 and cpu_stall=0.
  // Device side: dev_req[i] stays high until the cycle dev_ready[i]=1 is seen.
  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_we, dev_ready, dev_rdata, dev_irq,
    output cpu_rdata, cpu_stall, cpu_err, dev_req, dev_addr, dev_wdata, dev_we, irq_out
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_we, dev_ready, dev_rdata, dev_irq,
    input  cpu_rdata, cpu_stall, cpu_err, dev_req, dev_addr, dev_wdata, dev_we, irq_out
  );
endinterface

// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: decodes CPU accesses onto NUM_DEV device windows.
// Optional access timeout enabled by defining MMIO_BRIDGE_TIMEOUT_EN.
module mmio_bridge #(
  parameter int          NUM_DEV  = 2,
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
  parameter int          DEV_SPAN = 16,
  parameter int          TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           reset,
  mmio_bridge_if.slave   bus,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_DEV-1:0] sel_q, sel_d;
  logic [NUM_DEV-1:0] irq_q, irq_d;
  logic [NUM_DEV-1:0] hit_vec;
  logic [31:0]        dev_addr_q, dev_addr_d;
  logic [31:0]        dev_wdata_q, dev_wdata_d;
  logic [3:0]         dev_we_q, dev_we_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [31:0]        addr_w, off_w, base_v, rd_sel;
  logic               miss, accept, ready_sel, timeout_w;

  // Window decode on the word-aligned address; 33-bit compare avoids wrap at the top of memory.
  always_comb begin
    addr_w  = bus.cpu_addr & ~32'd3;
    hit_vec = '0;
    off_w   = '0;
    base_v  = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      base_v = DEV_BASE + 32'(i * DEV_SPAN);
      if (({1'b0, addr_w} >= {1'b0, base_v}) &&
          ({1'b0, addr_w} <  ({1'b0, base_v} + 33'(DEV_SPAN)))) begin
        hit_vec[i] = 1'b1;
        off_w      = addr_w - base_v;
      end
    end
  end

  assign miss   = ~|hit_vec;
  assign accept = (state_q == IDLE) && bus.cpu_req;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (sel_q[i]) rd_sel = bus.dev_rdata[32*i +: 32];
    end
  end

  assign ready_sel = |(bus.dev_ready & sel_q);

`ifdef MMIO_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Ready in the timeout cycle still completes normally (ready_sel is checked first).
  assign timeout_w = (state_q == ACCESS) && !ready_sel && (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if ((state_q == ACCESS) && !ready_sel) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign timeout_w      = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cpu_req) state_d = miss ? DONE : ACCESS;
      ACCESS:  if (ready_sel || timeout_w) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.dev_req   = (state_q == ACCESS) ? sel_q : '0;
    bus.cpu_stall = bus.cpu_req && (state_q != DONE);
    state_o       = state_q;
  end

  always_comb begin
    sel_d       = sel_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    dev_we_d    = dev_we_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    irq_d       = bus.dev_irq;
    if (accept && !miss) begin
      sel_d       = hit_vec;
      dev_addr_d  = off_w;
      dev_wdata_d = bus.cpu_wdata;
      dev_we_d    = bus.cpu_we;
    end
    if (accept && miss) begin
      rdata_d = '0;
      err_d   = 1'b1;
    end
    if (state_q == ACCESS) begin
      if (ready_sel) begin
        rdata_d = (dev_we_q == 4'd0) ? rd_sel : 32'd0;
      end else if (timeout_w) begin
        rdata_d = 32'hDEAD_BEEF;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q       <= '0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      dev_we_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      irq_q       <= '0;
    end else begin
      sel_q       <= sel_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      dev_we_q    <= dev_we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_err   = err_q;
  assign bus.dev_addr  = dev_addr_q;
  assign bus.dev_wdata = dev_wdata_q;
  assign bus.dev_we    = dev_we_q;
  assign bus.irq_out   = irq_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Testbench for mmio_bridge: CPU/device driver, completion monitor with expected queue.
// Covers the timeout path when built with MMIO_BRIDGE_TIMEOUT_EN.
module tb_mmio_bridge;
  localparam int          NUM_DEV = 2;
  localparam logic [31:0] BASE    = 32'h0000_7F00;
  localparam int          SPAN    = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dut_state;

  always #5 clk = ~clk;

  mmio_bridge_if #(.NUM_DEV(NUM_DEV)) bus();

  mmio_bridge #(
    .NUM_DEV (NUM_DEV),
    .DEV_BASE(BASE),
    .DEV_SPAN(SPAN),
    .TIMEOUT (4)
  ) dut (
    .clk    (clk),
    .reset  (rst_n),
    .bus    (bus),
    .state_o(dut_state)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        err_model = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every cycle the CPU sees req && !stall, one expected result is consumed.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.cpu_req === 1'b1 && bus.cpu_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL completion: got unexpected completion, expected none at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("cpu_rdata", bus.cpu_rdata, mon_e[31:0]);
        check("cpu_err", 32'(bus.cpu_err), 32'(mon_e[32]));
      end
    end
  end

  // One full CPU access with a device answering after lat wait cycles.
  // Entry and exit: #1 after a rising edge with the bridge idle.
  task automatic do_txn(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rd);
    logic [31:0]           a, off, exp_rd;
    logic                  hit;
    int                    k, stalls;
    logic [NUM_DEV-1:0]    oh, noise;
    logic [NUM_DEV*32-1:0] rv;
    a   = addr & ~32'd3;
    hit = (a >= BASE) && ((a - BASE) < 32'(NUM_DEV * SPAN));
    k   = hit ? int'((a - BASE) / SPAN) : 0;
    off = a - BASE - 32'(k * SPAN);
    oh  = hit ? NUM_DEV'(1 << k) : '0;
    if (!hit) err_model = 1'b1;
    exp_rd = (!hit || we != 4'd0) ? 32'd0 : rd;
    exp_q.push_back({err_model, exp_rd});

    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_we    = we;
    stalls = 0;
    @(negedge clk);
    if (bus.cpu_stall) stalls++;
    check("dev_req_accept", 32'(bus.dev_req), 32'd0);
    if (hit) begin
      for (int j = 0; j <= lat; j++) begin
        @(posedge clk); #1;
        noise = NUM_DEV'($urandom);
        bus.dev_ready = ((j == lat) ? oh : '0) | (noise & ~oh);
        for (int s = 0; s < NUM_DEV; s++) rv[32*s +: 32] = $urandom;
        rv[32*k +: 32] = rd;
        bus.dev_rdata = rv;
        @(negedge clk);
        if (bus.cpu_stall) stalls++;
        check("dev_req", 32'(bus.dev_req), 32'(oh));
        check("dev_addr", bus.dev_addr, off);
        check("dev_we", 32'(bus.dev_we), 32'(we));
        check("dev_wdata", bus.dev_wdata, wdata);
      end
    end
    @(posedge clk); #1;
    bus.dev_ready = '0;
    @(negedge clk);
    if (bus.cpu_stall) stalls++;
    check("dev_req_done", 32'(bus.dev_req), 32'd0);
    check("stall_cycles", 32'(stalls), hit ? 32'(lat + 2) : 32'd1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_DEV-1:0] iv;
    logic [31:0]        addr;
    logic [3:0]         we;
    int                 stalls, kind, k, gap;

    rst_n         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_we    = '0;
    bus.dev_ready = '0;
    bus.dev_rdata = '0;
    bus.dev_irq   = '0;

    #12;
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_cpu_err", 32'(bus.cpu_err), 32'd0);
    check("rst_dev_req", 32'(bus.dev_req), 32'd0);
    check("rst_dev_addr", bus.dev_addr, 32'd0);
    check("rst_dev_wdata", bus.dev_wdata, 32'd0);
    check("rst_dev_we", 32'(bus.dev_we), 32'd0);
    check("rst_irq_out", 32'(bus.irq_out), 32'd0);
    check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (10) begin
      @(negedge clk);
      check("idle_dev_req", 32'(bus.dev_req), 32'd0);
      check("idle_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    end
    @(posedge clk); #1;

    bus.dev_irq = 2'b01;
    @(posedge clk); #1;
    check("irq_out", 32'(bus.irq_out), 32'h1);
    repeat (8) begin
      iv = NUM_DEV'($urandom);
      bus.dev_irq = iv;
      @(posedge clk); #1;
      check("irq_out", 32'(bus.irq_out), 32'(iv));
    end
    bus.dev_irq = '0;

    do_txn(32'h0000_7F14, 4'b0000, 32'h0, 0, 32'h1234_5678);
    do_txn(32'h0000_7F08, 4'b0011, 32'hAABB_CCDD, 3, 32'h5555_AAAA);
    do_txn(32'h0000_7F1F, 4'b0000, 32'h0, 1, 32'h0BAD_F00D);
    do_txn(32'h0000_1000, 4'b0000, 32'h0, 0, 32'h0);
    do_txn(32'h0000_7EFC, 4'b0000, 32'h0, 0, 32'h0);
    do_txn(32'h0000_7F20, 4'b1111, 32'h0, 0, 32'h0);
    do_txn(32'h0000_7F00, 4'b0000, 32'h0, 2, 32'hCAFE_0001);

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_7F04;
    bus.cpu_we   = 4'd0;
    err_model    = 1'b1;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall) break;
      stalls++;
    end
    check("timeout_stall_cycles", 32'(stalls), 32'd5);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
`else
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_7F04;
    bus.cpu_we   = 4'd0;
    stalls = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.cpu_stall && bus.dev_req != 2'b10) stalls++;
    end
    check("no_timeout_stall_cycles", 32'(stalls), 32'd120);
    exp_q.push_back({err_model, 32'h7777_0123});
    @(posedge clk); #1;
    bus.dev_ready = 2'b01;
    bus.dev_rdata = {32'h0, 32'h7777_0123};
    @(posedge clk); #1;
    bus.dev_ready = '0;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
`endif

    repeat (60) begin
      kind = $urandom_range(0, 4);
      if (kind < 4) begin
        k    = $urandom_range(0, NUM_DEV - 1);
        addr = BASE + 32'(k * SPAN) + 32'($urandom_range(0, SPAN - 1));
      end else begin
        addr = $urandom;
      end
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      do_txn(addr, we, $urandom, $urandom_range(0, 3), $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_7F00;
    bus.cpu_we   = 4'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_dev_req_before", 32'(bus.dev_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_dev_req_after", 32'(bus.dev_req), 32'd0);
    check("abort_cpu_err", 32'(bus.cpu_err), 32'd0);
    check("abort_cpu_rdata", bus.cpu_rdata, 32'd0);
    bus.cpu_req = 1'b0;
    err_model   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(32'h0000_7F10, 4'b0000, 32'h0, 2, 32'h0FED_CBA9);
    repeat (2) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
